// File: rtl/simd_isa_pkg.sv
// Shared ISA definitions for the SIMD processor: opcode encoding, opcode field
// position and the fetch-stage state encoding.
package simd_isa_pkg;

  localparam int OPC_LSB = 0;
  localparam int OPC_MSB = 2;

  typedef enum logic [2:0] {
    OPC_LOADA   = 3'b010,
    OPC_LOADB   = 3'b011,
    OPC_MULTACC = 3'b100,
    OPC_STORE   = 3'b101,
    OPC_STOP    = 3'b110,
    OPC_ADDSUB  = 3'b111
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HALT  = 2'd2
  } fetch_state_e;

  function automatic logic is_stop(input logic [31:0] word);
    return word[OPC_MSB:OPC_LSB] == OPC_STOP;
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bundle: run control, instruction-store address/data, downstream
// valid/ready issue port and run status.
interface instr_fetch_unit_if #(parameter int N = 512);

  localparam int PCW = $clog2(N);

  logic           start;
  logic           abort;
  logic [PCW-1:0] pc_axi;
  logic [31:0]    instr_axi;
  logic [31:0]    instr_out;
  logic           instr_valid;
  logic           instr_ready;
  logic           busy;
  logic           done;
  logic           err_ovf;
  logic [PCW:0]   issue_cnt;

  modport master (
    input  start, abort, instr_axi, instr_ready,
    output pc_axi, instr_out, instr_valid, busy, done, err_ovf, issue_cnt
  );

  modport slave (
    output start, abort, instr_axi, instr_ready,
    input  pc_axi, instr_out, instr_valid, busy, done, err_ovf, issue_cnt
  );

endinterface

// File: rtl/instr_fetch_unit.sv
// PC sequencer + one-entry issue register; word at PC is captured whenever the slot is free or being consumed.
// Latency: START edge puts PC 0 out, next edge captures word 0. Backpressure: ready low freezes PC and slot, no bubble on release.
module instr_fetch_unit
  import simd_isa_pkg::*;
#(
  parameter int N = 512
) (
  input  logic               clk,
  input  logic               rst,
  instr_fetch_unit_if.master bus
);

  localparam int              PCW     = $clog2(N);
  localparam logic [PCW-1:0]  PC_LAST = PCW'(N - 1);
  localparam logic [PCW:0]    CNT_MAX = '1;

  fetch_state_e   state_q, state_d;
  logic [PCW-1:0] pc_q, pc_d;
  logic [31:0]    instr_q, instr_d;
  logic           valid_q, valid_d;
  logic           done_q, done_d;
  logic           err_q, err_d;
  logic [PCW:0]   cnt_q, cnt_d;

  logic load;
  logic fire;
  logic restart;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    done_d  = done_q;
    err_d   = err_q;
    cnt_d   = cnt_q;

    load    = !valid_q || bus.instr_ready;
    fire    = valid_q && bus.instr_ready;
    // HALT only rearms once the overflow word has drained.
    restart = bus.start && ((state_q == ST_IDLE) || (state_q == ST_HALT && !valid_q));

    if (fire && cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end

    if (bus.abort) begin
      state_d = ST_IDLE;
      valid_d = 1'b0;
      pc_d    = '0;
      cnt_d   = cnt_q;
    end else if (restart) begin
      state_d = ST_FETCH;
      pc_d    = '0;
      done_d  = 1'b0;
      err_d   = 1'b0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (load) begin
            if (is_stop(bus.instr_axi)) begin
              // STOP ends the run without ever reaching the issue slot.
              valid_d = 1'b0;
              done_d  = 1'b1;
              state_d = ST_HALT;
            end else begin
              instr_d = bus.instr_axi;
              valid_d = 1'b1;
              if (pc_q == PC_LAST) begin
                err_d   = 1'b1;
                state_d = ST_HALT;
              end else begin
                pc_d = pc_q + 1'b1;
              end
            end
          end
        end
        ST_HALT: begin
          if (fire) begin
            valid_d = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.pc_axi      = pc_q;
  assign bus.instr_out   = instr_q;
  assign bus.instr_valid = valid_q;
  assign bus.busy        = (state_q == ST_FETCH);
  assign bus.done        = done_q;
  assign bus.err_ovf     = err_q;
  assign bus.issue_cnt   = cnt_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: random programs in a small store, issued stream
// compared against the store contents up to the first STOP or the last word.
module tb_instr_fetch_unit;
  import simd_isa_pkg::*;

  localparam int N   = 8;
  localparam int PCW = $clog2(N);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instr_fetch_unit_if #(.N(N)) bus ();
  instr_fetch_unit #(.N(N)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [31:0] mem [N];
  assign bus.instr_axi = mem[bus.pc_axi];

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] exp_q [$];
  bit          mon_en = 1'b0;
  bit          hold_prev = 1'b0;
  logic [31:0] out_prev;
  int          valid_cycles;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard of issued words plus stability of a stalled slot.
  always @(negedge clk) begin
    if (mon_en) begin
      if (hold_prev) begin
        chk("hold_valid", bus.instr_valid, 1);
        chk("hold_data", bus.instr_out, out_prev);
      end
      if (bus.instr_valid) valid_cycles++;
      if (bus.instr_valid && bus.instr_ready) begin
        if (exp_q.size() == 0) chk("extra_issue_q_size", exp_q.size(), 1);
        else chk("issue_word", bus.instr_out, exp_q.pop_front());
      end
      hold_prev = bus.instr_valid && !bus.instr_ready && !bus.abort;
      out_prev  = bus.instr_out;
    end else begin
      hold_prev = 1'b0;
    end
  end

  // Reference: the run issues every word before the first STOP, or all N words.
  function automatic void model(output int len, output bit stop_seen);
    len = N;
    stop_seen = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (mem[i][2:0] == 3'b110) begin
        len = i;
        stop_seen = 1'b1;
        break;
      end
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_prog(input int stop_at);
    logic [2:0]  ops [7] = '{3'b010, 3'b011, 3'b100, 3'b101, 3'b111, 3'b000, 3'b001};
    logic [31:0] r;
    logic [2:0]  op;
    for (int i = 0; i < N; i++) begin
      r  = $urandom();
      op = ops[$urandom_range(0, 6)];
      if (i == stop_at) op = 3'b110;
      mem[i] = {r[31:8], 5'(i), op};
    end
  endtask

  task automatic load_test_prog();
    logic [2:0] ops [5] = '{3'b010, 3'b011, 3'b100, 3'b101, 3'b110};
    load_prog(-1);
    for (int i = 0; i < 5; i++) mem[i] = {mem[i][31:3], ops[i]};
  endtask

  task automatic chk_reset_vals();
    chk("rst_pc", bus.pc_axi, 0);
    chk("rst_out", bus.instr_out, 0);
    chk("rst_valid", bus.instr_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_err", bus.err_ovf, 0);
    chk("rst_cnt", bus.issue_cnt, 0);
  endtask

  task automatic begin_run(output int len, output bit stop_seen);
    model(len, stop_seen);
    exp_q.delete();
    for (int i = 0; i < len; i++) exp_q.push_back(mem[i]);
    valid_cycles = 0;
    mon_en = 1'b1;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("start_pc", bus.pc_axi, 0);
    chk("start_busy", bus.busy, 1);
    chk("start_flags", {bus.done, bus.err_ovf}, 0);
    chk("start_cnt", bus.issue_cnt, 0);
  endtask

  task automatic finish_run(input int rdy_pct, input int len, input bit stop_seen);
    int budget = 400;
    while (!((bus.done || bus.err_ovf) && !bus.instr_valid) && budget > 0) begin
      bus.instr_ready = ($urandom_range(0, 99) < rdy_pct);
      step();
      budget--;
    end
    chk("run_in_budget", budget > 0, 1);
    chk("end_done", bus.done, stop_seen);
    chk("end_err_ovf", bus.err_ovf, !stop_seen);
    chk("end_cnt", bus.issue_cnt, len);
    chk("end_pc", bus.pc_axi, stop_seen ? len : N - 1);
    chk("end_busy", bus.busy, 0);
    chk("end_drained", exp_q.size(), 0);
  endtask

  initial begin
    int len;
    bit stop_seen;
    int budget;

    rst = 1'b1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.instr_ready = 1'b0;
    load_test_prog();
    #2;
    chk_reset_vals();
    step();
    rst = 1'b0;
    step();

    // Straight run, consumer always ready: words 0..3 back to back, DONE after STOP.
    bus.instr_ready = 1'b1;
    begin_run(len, stop_seen);
    chk("t1_len", len, 4);
    chk("t1_first_valid", bus.instr_valid, 0);
    for (int c = 1; c <= len + 1; c++) begin
      step();
      chk("t1_valid", bus.instr_valid, c <= len);
      if (c <= len) chk("t1_word", bus.instr_out, mem[c-1]);
      chk("t1_done", bus.done, c == len + 1);
    end
    finish_run(100, len, stop_seen);
    chk("t1_no_bubble", valid_cycles, len);

    // Same program, three stalled cycles on word 1.
    bus.instr_ready = 1'b1;
    begin_run(len, stop_seen);
    step();
    step();
    chk("t2_word1", bus.instr_out, mem[1]);
    bus.instr_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("t2_stall_out", bus.instr_out, mem[1]);
      chk("t2_stall_pc", bus.pc_axi, 2);
    end
    finish_run(100, len, stop_seen);

    // No STOP: overflow at the last word; START ignored until it drains.
    load_prog(-1);
    bus.instr_ready = 1'b1;
    begin_run(len, stop_seen);
    budget = 50;
    while (!bus.err_ovf && budget > 0) begin
      step();
      budget--;
    end
    chk("t3_ovf_in_budget", budget > 0, 1);
    bus.instr_ready = 1'b0;
    chk("t3_last_word", bus.instr_out, mem[N-1]);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("t3_start_ign_busy", bus.busy, 0);
    chk("t3_start_ign_err", bus.err_ovf, 1);
    chk("t3_start_ign_pc", bus.pc_axi, N - 1);
    bus.instr_ready = 1'b1;
    step();
    bus.instr_ready = 1'b0;
    chk("t3_drained_valid", bus.instr_valid, 0);
    chk("t3_cnt", bus.issue_cnt, N);
    chk("t3_done", bus.done, 0);
    begin_run(len, stop_seen);
    finish_run(70, len, stop_seen);

    // ABORT while word 2 is held, then START+ABORT together.
    bus.instr_ready = 1'b1;
    begin_run(len, stop_seen);
    budget = 20;
    while (!(bus.instr_valid && bus.instr_out == mem[2]) && budget > 0) begin
      step();
      budget--;
    end
    chk("t4_word2_in_budget", budget > 0, 1);
    bus.instr_ready = 1'b0;
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    exp_q.delete();
    chk("t4_valid", bus.instr_valid, 0);
    chk("t4_busy", bus.busy, 0);
    chk("t4_pc", bus.pc_axi, 0);
    chk("t4_cnt", bus.issue_cnt, 2);
    bus.start = 1'b1;
    bus.abort = 1'b1;
    step();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    step();
    chk("t4_both_busy", bus.busy, 0);
    chk("t4_both_valid", bus.instr_valid, 0);
    chk("t4_both_pc", bus.pc_axi, 0);

    // Asynchronous reset in the middle of a run, then a clean rerun.
    load_prog(5);
    bus.instr_ready = 1'b1;
    begin_run(len, stop_seen);
    step();
    step();
    mon_en = 1'b0;
    #3 rst = 1'b1;
    #1 chk_reset_vals();
    #2 rst = 1'b0;
    step();
    begin_run(len, stop_seen);
    finish_run(80, len, stop_seen);

    // Random programs under random backpressure.
    for (int it = 0; it < 20; it++) begin
      int s = $urandom_range(0, N + 3);
      load_prog(s < N ? s : -1);
      begin_run(len, stop_seen);
      finish_run($urandom_range(30, 100), len, stop_seen);
    end

    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
